// File: rtl/axi_pkg.sv
// Shared AXI-side types; the isolate sequencer state encoding lives here so
// status/CSR logic can decode it without depending on the controller module.
package axi_pkg;

    typedef enum logic [2:0] {
        Connected = 3'd0,
        Isolating = 3'd1,
        Settle    = 3'd2,
        Isolated  = 3'd3,
        Releasing = 3'd4
    } isolate_ctrl_state_e;

endpackage

// File: rtl/axi_isolate_ctrl.sv
// Sequencer for axi_isolate: turns a 4-phase req/ack into isolate, settle and
// release phases, with a sticky watchdog flag for drains that never finish.
module axi_isolate_ctrl
    import axi_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned SettleCycles  = 4,
    parameter bit          ResetIsolated = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic ack_o,
    output logic isolate_o,
    input  logic isolated_i,
    input  logic clr_timeout_i,
    output logic timeout_o,
    output logic busy_o
);

    localparam int unsigned MaxCycles = (TimeoutCycles > SettleCycles) ? TimeoutCycles : SettleCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] CntMax      = CntW'(MaxCycles);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'((SettleCycles == 0) ? 0 : SettleCycles - 1);
    localparam isolate_ctrl_state_e ResetState = ResetIsolated ? Isolated : Connected;

    isolate_ctrl_state_e state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                timeout_q, timeout_d, timeout_set;

    // One counter serves both Isolating and Settle; it never wraps so a long
    // drain cannot re-trigger the watchdog compare by rolling over.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        case (state_q)
            Connected: begin
                if (req_i) state_d = Isolating;
            end
            Isolating: begin
                cnt_d = cnt_inc;
                if (isolated_i) begin
                    state_d = (SettleCycles == 0) ? Isolated : Settle;
                end else if (!req_i) begin
                    state_d = Releasing;
                end else if (cnt_q == TimeoutLast) begin
                    timeout_set = 1'b1;
                end
            end
            Settle: begin
                cnt_d = cnt_inc;
                if (!req_i) begin
                    state_d = Releasing;
                end else if (!isolated_i) begin
                    state_d = Isolating;
                end else if (cnt_q == SettleLast) begin
                    state_d = Isolated;
                end
            end
            Isolated: begin
                if (!req_i) state_d = Releasing;
            end
            Releasing: begin
                // req_i is deliberately not looked at until the release completes.
                if (!isolated_i) state_d = Connected;
            end
            default: state_d = ResetState;
        endcase
        if (state_d != state_q) cnt_d = '0;
        timeout_d = timeout_set | (timeout_q & ~clr_timeout_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ResetState;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign isolate_o = (state_q == Isolating) || (state_q == Settle) || (state_q == Isolated);
    assign ack_o     = (state_q == Isolated);
    assign busy_o    = (state_q == Isolating) || (state_q == Settle) || (state_q == Releasing);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Directed bench for axi_isolate_ctrl: three instances share stimulus
// (reset-isolated, reset-connected, and a zero-settle variant).
module tb_axi_isolate_ctrl;

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    logic req, isolated, clr;

    logic a_ack, a_iso, a_to, a_busy;
    logic b_ack, b_iso, b_to, b_busy;
    logic c_ack, c_iso, c_to, c_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_isolate_ctrl #(.TimeoutCycles(8), .SettleCycles(4), .ResetIsolated(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n_a), .req_i(req), .ack_o(a_ack), .isolate_o(a_iso),
        .isolated_i(isolated), .clr_timeout_i(clr), .timeout_o(a_to), .busy_o(a_busy)
    );

    axi_isolate_ctrl #(.TimeoutCycles(8), .SettleCycles(4), .ResetIsolated(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n_b), .req_i(req), .ack_o(b_ack), .isolate_o(b_iso),
        .isolated_i(isolated), .clr_timeout_i(clr), .timeout_o(b_to), .busy_o(b_busy)
    );

    axi_isolate_ctrl #(.TimeoutCycles(8), .SettleCycles(0), .ResetIsolated(1'b0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n_b), .req_i(req), .ack_o(c_ack), .isolate_o(c_iso),
        .isolated_i(isolated), .clr_timeout_i(clr), .timeout_o(c_to), .busy_o(c_busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        req = 1'b0; isolated = 1'b1; clr = 1'b0;

        // Reset state, then release from the reset-isolated condition.
        step(2);
        check_eq("a_rst_iso", a_iso, 1'b1);
        check_eq("a_rst_ack", a_ack, 1'b1);
        check_eq("a_rst_busy", a_busy, 1'b0);
        check_eq("a_rst_to", a_to, 1'b0);
        check_eq("b_rst_iso", b_iso, 1'b0);
        check_eq("b_rst_ack", b_ack, 1'b0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        step(1);
        check_eq("a_rel_iso", a_iso, 1'b0);
        check_eq("a_rel_ack", a_ack, 1'b0);
        check_eq("a_rel_busy", a_busy, 1'b1);
        check_eq("b_tol_iso", b_iso, 1'b0);
        check_eq("b_tol_busy", b_busy, 1'b0);
        step(1);
        check_eq("a_rel_hold", a_busy, 1'b1);
        isolated = 1'b0;
        step(1);
        check_eq("a_conn_busy", a_busy, 1'b0);
        check_eq("a_conn_iso", a_iso, 1'b0);

        // Isolate with a 3-cycle drain and full settle; zero-settle variant skips Settle.
        req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check_eq($sformatf("b_drain_iso%0d", i), b_iso, 1'b1);
            check_eq($sformatf("b_drain_ack%0d", i), b_ack, 1'b0);
        end
        isolated = 1'b1;
        step(1);
        check_eq("c_nosettle_ack", c_ack, 1'b1);
        check_eq("b_settle_busy", b_busy, 1'b1);
        for (int i = 5; i <= 7; i++) begin
            step(1);
            check_eq($sformatf("b_settle_ack%0d", i), b_ack, 1'b0);
            check_eq($sformatf("b_settle_iso%0d", i), b_iso, 1'b1);
        end
        step(1);
        check_eq("b_ack_c8", b_ack, 1'b1);
        check_eq("b_ack_busy", b_busy, 1'b0);
        req = 1'b0;
        step(1);
        check_eq("b_drop_ack", b_ack, 1'b0);
        check_eq("b_drop_iso", b_iso, 1'b0);
        req = 1'b1;
        step(1);
        check_eq("b_noreiso", b_iso, 1'b0);
        check_eq("b_noreiso_busy", b_busy, 1'b1);
        req = 1'b0; isolated = 1'b0;
        step(1);
        check_eq("b_back_conn", b_busy, 1'b0);

        // Watchdog: 8 cycles in Isolating without isolated_i.
        req = 1'b1;
        step(7);
        check_eq("b_to_early", b_to, 1'b0);
        step(1);
        check_eq("b_to_c7", b_to, 1'b0);
        step(1);
        check_eq("b_to_set", b_to, 1'b1);
        check_eq("b_to_iso", b_iso, 1'b1);
        clr = 1'b1;
        step(1);
        check_eq("b_to_clr", b_to, 1'b0);
        check_eq("b_to_clr_iso", b_iso, 1'b1);
        clr = 1'b0;
        req = 1'b0;
        step(2);
        req = 1'b1;
        step(8);
        check_eq("b_to_pre", b_to, 1'b0);
        clr = 1'b1;
        step(1);
        check_eq("b_to_setprio", b_to, 1'b1);
        clr = 1'b0;
        req = 1'b0;
        step(2);
        check_eq("b_to_sticky", b_to, 1'b1);
        check_eq("b_to_sticky_conn", b_busy, 1'b0);
        clr = 1'b1;
        step(1);
        check_eq("b_to_clr2", b_to, 1'b0);
        clr = 1'b0;

        // Abort during Settle: no ack pulse.
        req = 1'b1;
        step(1);
        isolated = 1'b1;
        step(1);
        check_eq("b_ab_ack0", b_ack, 1'b0);
        step(1);
        check_eq("b_ab_ack1", b_ack, 1'b0);
        req = 1'b0;
        step(1);
        check_eq("b_ab_ack2", b_ack, 1'b0);
        check_eq("b_ab_iso", b_iso, 1'b0);
        check_eq("b_ab_busy", b_busy, 1'b1);
        isolated = 1'b0;
        step(1);
        check_eq("b_ab_conn", b_busy, 1'b0);

        // isolated_i glitch during Settle restarts the full settle.
        req = 1'b1;
        step(1);
        isolated = 1'b1;
        step(3);
        isolated = 1'b0;
        step(1);
        check_eq("b_gl_iso", b_iso, 1'b1);
        check_eq("b_gl_ack", b_ack, 1'b0);
        isolated = 1'b1;
        step(4);
        check_eq("b_gl_late", b_ack, 1'b0);
        step(1);
        check_eq("b_gl_ack_ok", b_ack, 1'b1);

        // Reset pulse while isolated returns to Connected next cycle.
        rst_n_b = 1'b0;
        step(1);
        check_eq("b_mid_rst_iso", b_iso, 1'b0);
        check_eq("b_mid_rst_ack", b_ack, 1'b0);
        check_eq("b_mid_rst_to", b_to, 1'b0);
        check_eq("b_mid_rst_busy", b_busy, 1'b0);
        rst_n_b = 1'b1;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
